// File: rtl/vend_word_splitter.sv
// vend_word_splitter: buffers 16-bit words in a small FIFO and serializes each
// word into two bytes on a valid/ready byte stream.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst_n      asynchronous active-low reset
//   in_word    packed word {first_byte, second_byte}
//   in_valid   in_word is valid this cycle
//   in_ready   word accepted this cycle (registered, independent of out_ready)
//   out_byte   current output byte
//   out_valid  out_byte is valid
//   out_ready  consumer accepts out_byte this cycle
//   out_last   high with the second byte of a word
//   fill_level words held in the FIFO, not counting the word being serialized
module vend_word_splitter #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [15:0]                 in_word,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [7:0]                  out_byte,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFirst, StSecond} state_e;

  state_e            state_q, state_d;
  logic [15:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [15:0]       hold_q, hold_d;
  logic              in_ready_q, in_ready_d;
  logic              push, pop;

  assign push       = in_valid && in_ready_q;
  assign in_ready   = in_ready_q;
  assign fill_level = cnt_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; pop is the FSM's request to load the FIFO head into hold.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cnt_q != '0) begin
          pop     = 1'b1;
          state_d = StFirst;
        end
      end
      StFirst: begin
        if (out_ready) state_d = StSecond;
      end
      StSecond: begin
        if (out_ready) begin
          if (cnt_q != '0) begin
            // Back-to-back reload keeps the byte stream free of bubbles.
            pop     = 1'b1;
            state_d = StFirst;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, decoded from state and hold only so it is stable under stall.
  always_comb begin
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    unique case (state_q)
      StFirst: begin
        out_valid = 1'b1;
        out_byte  = MSB_FIRST ? hold_q[15:8] : hold_q[7:0];
      end
      StSecond: begin
        out_valid = 1'b1;
        out_last  = 1'b1;
        out_byte  = MSB_FIRST ? hold_q[7:0] : hold_q[15:8];
      end
      default: ;
    endcase
  end

  // FIFO bookkeeping and hold register next state.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    hold_d   = pop ? mem_q[rd_ptr_q] : hold_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    // Registered from the next count: a pop out of full reopens the input only
    // one cycle later, and in_ready never sees out_ready combinationally.
    in_ready_d = (cnt_d != FullCnt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      hold_q     <= '0;
      in_ready_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      hold_q     <= hold_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Storage needs no reset: pointers and count define which entries are live.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_word;
  end

endmodule

// File: tb/tb_vend_word_splitter.sv
module tb_vend_word_splitter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic       in_ready_m, out_valid_m, out_last_m;
  logic [7:0] out_byte_m;
  logic [2:0] fill_m;
  logic       in_ready_l, out_valid_l, out_last_l;
  logic [7:0] out_byte_l;
  logic [2:0] fill_l;

  int total = 0;
  int bad   = 0;

  logic [8:0]  got [$];
  logic [8:0]  mq  [$];
  logic [8:0]  lq  [$];
  logic [8:0]  e9;
  logic [15:0] w3 [5];
  logic [8:0]  exp4 [12];

  always #5 clk = ~clk;

  vend_word_splitter #(.FIFO_DEPTH(4), .MSB_FIRST(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready_m),
    .out_byte   (out_byte_m),
    .out_valid  (out_valid_m),
    .out_ready  (out_ready),
    .out_last   (out_last_m),
    .fill_level (fill_m)
  );

  vend_word_splitter #(.FIFO_DEPTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_word    (in_word),
    .in_valid   (in_valid),
    .in_ready   (in_ready_l),
    .out_byte   (out_byte_l),
    .out_valid  (out_valid_l),
    .out_ready  (out_ready),
    .out_last   (out_last_l),
    .fill_level (fill_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    w3   = '{16'h1101, 16'h2202, 16'h3303, 16'h4404, 16'h5505};
    exp4 = '{9'h011, 9'h101, 9'h022, 9'h102, 9'h033, 9'h103,
             9'h044, 9'h104, 9'h055, 9'h105, 9'h066, 9'h106};
    rst_n = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset values.
    tick(); tick();
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_out_last", out_last_m, 0);
    chk("rst_out_byte", out_byte_m, 8'h00);
    chk("rst_in_ready", in_ready_m, 0);
    chk("rst_fill", fill_m, 0);
    chk("rst_out_byte_l", out_byte_l, 8'h00);
    rst_n = 1'b1;
    chk("rel_in_ready_pre", in_ready_m, 0);
    tick();
    chk("rel_in_ready_post", in_ready_m, 1);

    // Single word, MSB first, one cycle latency.
    in_word = 16'hA55A; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("sw_fill1", fill_m, 1);
    chk("sw_valid_lat", out_valid_m, 0);
    tick();
    chk("sw_b0", {out_valid_m, out_last_m, out_byte_m}, {2'b10, 8'hA5});
    chk("sw_b0_l", {out_valid_l, out_last_l, out_byte_l}, {2'b10, 8'h5A});
    tick();
    chk("sw_b1", {out_valid_m, out_last_m, out_byte_m}, {2'b11, 8'h5A});
    chk("sw_b1_l", {out_valid_l, out_last_l, out_byte_l}, {2'b11, 8'hA5});
    tick();
    chk("sw_idle", out_valid_m, 0);
    chk("sw_fill0", fill_m, 0);

    // Two words back to back, LSB-first byte swap, no bubble.
    in_word = 16'h1234; in_valid = 1'b1;
    tick();
    chk("ord_ready2", in_ready_m, 1);
    in_word = 16'hABCD;
    tick();
    in_valid = 1'b0;
    begin
      logic [9:0] el [4];
      logic [9:0] em [4];
      el = '{{2'b10, 8'h34}, {2'b11, 8'h12}, {2'b10, 8'hCD}, {2'b11, 8'hAB}};
      em = '{{2'b10, 8'h12}, {2'b11, 8'h34}, {2'b10, 8'hAB}, {2'b11, 8'hCD}};
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("ord_l%0d", i), {out_valid_l, out_last_l, out_byte_l}, el[i]);
        chk($sformatf("ord_m%0d", i), {out_valid_m, out_last_m, out_byte_m}, em[i]);
        tick();
      end
    end
    chk("ord_idle", out_valid_m, 0);

    // Backpressure: five words, output stalled.
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_word = w3[i];
      chk($sformatf("bp_ready%0d", i), in_ready_m, 1);
      tick();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bp_full_ready%0d", i), in_ready_m, 0);
      chk($sformatf("bp_fill%0d", i), fill_m, 4);
      chk($sformatf("bp_stable%0d", i), {out_valid_m, out_last_m, out_byte_m}, {2'b10, 8'h11});
      tick();
    end

    // Full boundary: pop out of full reopens input one cycle later.
    in_word = 16'h6606; in_valid = 1'b1; out_ready = 1'b1;
    got.delete();
    chk("fb_ready_a", in_ready_m, 0);
    got.push_back({out_last_m, out_byte_m});
    tick();
    chk("fb_ready_popcycle", in_ready_m, 0);
    got.push_back({out_last_m, out_byte_m});
    tick();
    chk("fb_ready_after", in_ready_m, 1);
    chk("fb_fill3", fill_m, 3);
    got.push_back({out_last_m, out_byte_m});
    tick();
    in_valid = 1'b0;
    for (int n = 0; n < 30 && out_valid_m; n++) begin
      got.push_back({out_last_m, out_byte_m});
      tick();
    end
    chk("fb_drain_count", got.size(), 12);
    for (int i = 0; i < 12 && i < got.size(); i++)
      chk($sformatf("fb_drain%0d", i), got[i], exp4[i]);

    // Reset while SECOND is stalled with another word queued.
    in_word = 16'hBEEF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_word = 16'h7777; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("rm_stalled", {out_valid_m, out_last_m, out_byte_m}, {2'b11, 8'hEF});
    chk("rm_fill1", fill_m, 1);
    rst_n = 1'b0;
    #1;
    chk("rm_valid0", out_valid_m, 0);
    chk("rm_fill0", fill_m, 0);
    chk("rm_ready0", in_ready_m, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rm_rel_ready", in_ready_m, 1);
    chk("rm_rel_fill", fill_m, 0);
    chk("rm_rel_valid", out_valid_m, 0);
    in_word = 16'h0F0F; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    got.delete();
    for (int n = 0; n < 8; n++) begin
      if (out_valid_m) got.push_back({out_last_m, out_byte_m});
      tick();
    end
    chk("rm_count", got.size(), 2);
    if (got.size() >= 2) begin
      chk("rm_b0", got[0], 9'h00F);
      chk("rm_b1", got[1], 9'h10F);
    end

    // Random valid/ready against a byte-stream scoreboard.
    mq.delete(); lq.delete();
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_word   = 16'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      chk("rnd_fill_range", (fill_m <= 3'd4), 1);
      if (in_valid && in_ready_m) begin
        mq.push_back({1'b0, in_word[15:8]}); mq.push_back({1'b1, in_word[7:0]});
        lq.push_back({1'b0, in_word[7:0]});  lq.push_back({1'b1, in_word[15:8]});
      end
      if (out_valid_m && out_ready) begin
        e9 = 9'h1FF;
        if (mq.size() != 0) e9 = mq.pop_front();
        chk("rnd_msb", {out_last_m, out_byte_m}, e9);
      end
      if (out_valid_l && out_ready) begin
        e9 = 9'h1FF;
        if (lq.size() != 0) e9 = lq.pop_front();
        chk("rnd_lsb", {out_last_l, out_byte_l}, e9);
      end
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (out_valid_m) begin
        e9 = 9'h1FF;
        if (mq.size() != 0) e9 = mq.pop_front();
        chk("rnd_drain_msb", {out_last_m, out_byte_m}, e9);
      end
      if (out_valid_l) begin
        e9 = 9'h1FF;
        if (lq.size() != 0) e9 = lq.pop_front();
        chk("rnd_drain_lsb", {out_last_l, out_byte_l}, e9);
      end
      tick();
    end
    chk("rnd_left_msb", mq.size(), 0);
    chk("rnd_left_lsb", lq.size(), 0);
    chk("rnd_end_fill", fill_m, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vend_word_splitter.md
VEND_WORD_SPLITTER -- requirements
Module: vend_word_splitter

Interface
REQ-001 The block SHALL have parameter FIFO_DEPTH, default 4: number of 16-bit words buffered; power of two, minimum 2.
REQ-002 The block SHALL have parameter MSB_FIRST, default 1: 1 = emit word[15:8] first, 0 = emit word[7:0] first.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low, with ports named clk and rst_n.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 in_word  input  16  packed word {first_byte, second_byte}, producer side of the existing 2x8->16 packing.
REQ-007 in_valid  input  1  in_word is valid this cycle.
REQ-008 in_ready  output  1  the block accepts in_word this cycle.
REQ-009 out_byte  output  8  current output byte.
REQ-010 out_valid  output  1  out_byte is valid.
REQ-011 out_ready  input  1  the consumer accepts out_byte this cycle.
REQ-012 out_last  output  1  high with the second byte of a word.
REQ-013 fill_level  output  $clog2(FIFO_DEPTH)+1  words held in the FIFO, excluding the word being serialized.

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid && in_ready, and written to the FIFO tail.
REQ-015 in_ready SHALL be the registered value of !(fill_level == FIFO_DEPTH), with no combinational path from out_ready.
REQ-016 When full, the block SHALL hold in_ready low even if a pop occurs in the same cycle; the push waits one cycle.
REQ-017 A byte SHALL transfer on a rising edge where out_valid && out_ready.
REQ-018 While out_valid && !out_ready, out_byte, out_valid and out_last SHALL hold stable.
REQ-019 The serializer FSM SHALL have the states IDLE, FIRST and SECOND.
REQ-020 IDLE: out_valid=0; when fill_level>0, the block SHALL pop the head word into the hold register, move to FIRST and drive out_valid=1 on the next cycle.
REQ-021 FIRST: out_byte = hold[15:8] if MSB_FIRST, else hold[7:0]; out_last=0; on transfer the FSM SHALL move to SECOND.
REQ-022 SECOND: out_byte = the other half of hold; out_last=1; on transfer, if fill_level>0, the block SHALL pop and move to FIRST with no bubble cycle, else move to IDLE.
REQ-023 Latency: a word accepted at edge k into an empty block in IDLE SHALL present its first byte with out_valid=1 after edge k+1.
REQ-024 Sustained throughput SHALL be 2 bytes per 2 cycles with out_ready held high; the input sustains 1 word per 2 cycles.
REQ-025 Simultaneous push and pop with 0<fill_level<FIFO_DEPTH SHALL leave fill_level unchanged and preserve word order.
REQ-026 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH; fill_level SHALL never exceed FIFO_DEPTH or go below 0.
REQ-027 Word order in SHALL equal word order out; no word is dropped or duplicated.

Reset
REQ-028 While rst_n=0, the block SHALL drive out_valid=0, out_last=0, out_byte=8'h00, in_ready=0 and fill_level=0, with the FSM in IDLE and the pointers at 0.
REQ-029 On the first rising edge after rst_n deasserts, the block SHALL drive in_ready=1.
REQ-030 Reset asserted mid-word SHALL discard the hold register and FIFO contents; the remaining byte is never emitted.

Verification
REQ-031 Single word: push 16'hA55A with MSB_FIRST=1 and out_ready=1 -> bytes 8'hA5 (last=0) then 8'h5A (last=1) on consecutive cycles, starting one cycle after acceptance.
REQ-032 Order and byte swap: MSB_FIRST=0, push 16'h1234 then 16'hABCD -> byte stream 34,12,CD,AB, with out_last on 12 and AB, and no idle cycle between the words.
REQ-033 Backpressure: out_ready=0 with 5 words pushed -> in_ready drops after the 4th word enters the FIFO (1 in hold plus 4 in FIFO, fill_level=4); out_byte stays stable; releasing out_ready drains all 10 bytes in order.
REQ-034 Full boundary: fill_level=4, out_ready=1 and in_valid=1 held -> in_ready stays 0 the cycle of the pop and returns to 1 the next cycle; no word is lost.
REQ-035 Reset mid-word: assert rst_n=0 while SECOND is stalled -> out_valid=0 immediately; after release, fill_level=0 and a new word 16'h0F0F emits 0F,0F only.
REQ-036 Random: 10k random valid/ready patterns against a scoreboard model -> byte stream equals the split input stream, and fill_level stays in 0..FIFO_DEPTH.
